// File: rtl/rom_blit_ctrl_if.sv
// Bundle of the blit controller's control, ROM and VGA plot signals.
// "slave" is the controller's own view of the bundle.
// "master" is the surrounding system: the draw FSM, the image ROM and the VGA adapter.
interface rom_blit_ctrl_if;
    logic       start;
    logic [7:0] dst_x;
    logic [7:0] dst_y;
    logic       key_en;
    logic [7:0] rom_x;
    logic [7:0] rom_y;
    logic [2:0] rom_dout;
    logic [7:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       done;

    modport slave (
        input  start, dst_x, dst_y, key_en, rom_dout,
        output rom_x, rom_y, vga_x, vga_y, vga_colour, vga_plot, busy, done
    );

    modport master (
        output start, dst_x, dst_y, key_en, rom_dout,
        input  rom_x, rom_y, vga_x, vga_y, vga_colour, vga_plot, busy, done
    );
endinterface

// File: rtl/rom_blit_ctrl.sv
// Raster-order image ROM walker that streams pixels to the VGA plot port.
// Each pixel address is issued once per cycle. A valid tag and the image
// coordinates follow the address through two stages, which line up with
// the ROM's registered read. In the second stage the pixel is offset by
// the latched origin, clipped to the screen and optionally colour-keyed.
module rom_blit_ctrl #(
    parameter int          IMG_W      = 160,
    parameter int          IMG_H      = 120,
    parameter int          SCR_W      = 160,
    parameter int          SCR_H      = 120,
    parameter logic [2:0]  KEY_COLOUR = 3'b000
) (
    input  logic           clk,
    input  logic           rst,
    rom_blit_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [7:0] X_LAST = 8'(IMG_W - 1);
    localparam logic [7:0] Y_LAST = 8'(IMG_H - 1);
    localparam logic [8:0] SCR_W9 = 9'(SCR_W);
    localparam logic [8:0] SCR_H9 = 9'(SCR_H);

    state_t     state_reg, state_next;

    logic [7:0] dst_x_reg, dst_y_reg;
    logic       key_en_reg;

    // Stage 1: the address on the ROM port, tagged valid.
    logic [7:0] rom_x_reg, rom_y_reg;
    logic       s1_valid_reg;

    // Stage 2: the same image coordinates while rom_dout holds their pixel.
    logic [7:0] s2_ix_reg, s2_iy_reg;
    logic       s2_valid_reg;

    logic       drain_cnt_reg;

    logic [7:0] vga_x_reg, vga_y_reg;
    logic [2:0] vga_colour_reg;
    logic       vga_plot_reg;
    logic       busy_reg, done_reg;

    logic       last_addr;
    logic [8:0] sx, sy;
    logic       on_screen, keyed_out;

    assign last_addr = (rom_x_reg == X_LAST) && (rom_y_reg == Y_LAST);

    // The origin add is 9 bits wide, so a pixel past x=255 is clipped, not wrapped.
    assign sx        = {1'b0, dst_x_reg} + {1'b0, s2_ix_reg};
    assign sy        = {1'b0, dst_y_reg} + {1'b0, s2_iy_reg};
    assign on_screen = (sx < SCR_W9) && (sy < SCR_H9);
    assign keyed_out = key_en_reg && (bus.rom_dout == KEY_COLOUR);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. DRAIN lasts two cycles, so the final pixel has left the output stage before DONE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_addr) state_next = DRAIN;
            DRAIN:   if (drain_cnt_reg) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handles start acceptance, the raster address counter and the drain counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dst_x_reg     <= 8'd0;
            dst_y_reg     <= 8'd0;
            key_en_reg    <= 1'b0;
            rom_x_reg     <= 8'd0;
            rom_y_reg     <= 8'd0;
            s1_valid_reg  <= 1'b0;
            drain_cnt_reg <= 1'b0;
        end else begin
            s1_valid_reg  <= 1'b0;
            drain_cnt_reg <= (state_reg == DRAIN) ? ~drain_cnt_reg : 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        dst_x_reg    <= bus.dst_x;
                        dst_y_reg    <= bus.dst_y;
                        key_en_reg   <= bus.key_en;
                        rom_x_reg    <= 8'd0;
                        rom_y_reg    <= 8'd0;
                        s1_valid_reg <= 1'b1;
                    end
                end
                RUN: begin
                    // After the last address is issued, the address holds and no new slot is tagged valid.
                    if (!last_addr) begin
                        s1_valid_reg <= 1'b1;
                        if (rom_x_reg == X_LAST) begin
                            rom_x_reg <= 8'd0;
                            rom_y_reg <= rom_y_reg + 8'd1;
                        end else begin
                            rom_x_reg <= rom_x_reg + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Delays the tag and coordinates one cycle to match the ROM read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            s2_ix_reg    <= 8'd0;
            s2_iy_reg    <= 8'd0;
        end else begin
            s2_valid_reg <= s1_valid_reg;
            s2_ix_reg    <= rom_x_reg;
            s2_iy_reg    <= rom_y_reg;
        end
    end

    // Output stage. Position and colour follow every valid slot; only plot is gated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_x_reg      <= 8'd0;
            vga_y_reg      <= 8'd0;
            vga_colour_reg <= 3'd0;
            vga_plot_reg   <= 1'b0;
        end else begin
            vga_plot_reg <= 1'b0;
            if (s2_valid_reg) begin
                vga_x_reg      <= sx[7:0];
                vga_y_reg      <= sy[7:0];
                vga_colour_reg <= bus.rom_dout;
                vga_plot_reg   <= on_screen && !keyed_out;
            end
        end
    end

    // Status flags come from the next state, so both change on the same edge as the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            busy_reg <= (state_next == RUN) || (state_next == DRAIN);
            done_reg <= (state_next == DONE);
        end
    end

    assign bus.rom_x      = rom_x_reg;
    assign bus.rom_y      = rom_y_reg;
    assign bus.vga_x      = vga_x_reg;
    assign bus.vga_y      = vga_y_reg;
    assign bus.vga_colour = vga_colour_reg;
    assign bus.vga_plot   = vga_plot_reg;
    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;

endmodule

// File: doc/rom_blit_ctrl.md
Name: rom_blit_ctrl

Overview:
Sequencer that walks the 160x120 3-bit image ROM in raster order and streams each pixel to the VGA adapter's plot interface (x, y, colour, plot).
- Drives the ROM's x/y address inputs and absorbs the ROM's 1-cycle registered read latency.
- Offsets the image by a destination origin, clips to the screen, and can skip a transparent key colour.
- Sits between the top-level game/draw FSM (start/busy/done) and the ROM plus VGA adapter.

Parameters:
IMG_W, 160, image width in pixels (ROM x range 0..IMG_W-1)
IMG_H, 120, image height in pixels (ROM y range 0..IMG_H-1)
SCR_W, 160, screen width; plots with screen x >= SCR_W are suppressed
SCR_H, 120, screen height; plots with screen y >= SCR_H are suppressed
KEY_COLOUR, 3'b000, transparent colour when keying is enabled

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin a blit; sampled only in IDLE
dst_x  input  8  screen x of image pixel (0,0); latched on accepted start
dst_y  input  8  screen y of image pixel (0,0); latched on accepted start
key_en  input  1  1 = suppress pixels equal to KEY_COLOUR; latched on accepted start
rom_x  output  8  ROM column address, registered
rom_y  output  8  ROM row address, registered
rom_dout  input  3  ROM data, valid 1 cycle after rom_x/rom_y
vga_x  output  8  screen x of current plot, registered
vga_y  output  8  screen y of current plot, registered
vga_colour  output  3  pixel colour, registered
vga_plot  output  1  write strobe, registered, one cycle per visible pixel
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse at end of blit

Behaviour:
Reset:
- Async reset forces state IDLE.
- All outputs and internal registers go to 0, including pixel counters, latched dst and key_en.
- Reset mid-blit aborts immediately: no further plots and no done pulse.

States are IDLE, RUN, DRAIN, DONE.
- IDLE: if start=1 at edge E0, latch dst_x/dst_y/key_en, set rom_x=0, rom_y=0, busy=1, go to RUN. Otherwise hold; start=0 means no activity.
- RUN: each cycle issues one address. rom_x increments; at IMG_W-1 it wraps to 0 and rom_y increments. Once address (IMG_W-1, IMG_H-1) has been issued, the next edge goes to DRAIN and rom_x/rom_y hold.
- DRAIN: 2 cycles (internal counter) to flush the pipeline, then go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE.
- start is ignored while busy=1. start during the DONE cycle is ignored; a new start is accepted on the following IDLE cycle.

Pipeline:
- A valid tag plus the image coordinates travel with each address through a 2-stage pipeline.
- For pixel k (raster index, N = IMG_W*IMG_H), the address is registered at E0+k and vga_* is registered at E0+k+2.
- Throughput is 1 pixel per cycle, with no bubbles.
- The last plot is registered at E0+N+1. done is registered at E0+N+2 (busy falls on the same edge). Total busy duration is N+2 cycles.

Arithmetic:
- Screen coordinates are sx = dst_x + ix and sy = dst_y + iy, computed in 9 bits with no wrap.
- vga_x/vga_y take sx/sy[7:0].
- vga_colour = rom_dout.

Plot gating:
- vga_plot = valid AND sx < SCR_W AND sy < SCR_H AND NOT(key_en_latched AND rom_dout == KEY_COLOUR).
- vga_x/vga_y/vga_colour update on every valid pipeline slot, even when plot is suppressed.
- vga_plot is 0 in IDLE, DRAIN after flush, and DONE.

Boundary cases:
- Fully off-screen blit (dst_x >= SCR_W): sequences normally with zero plots and still pulses done.
- dst inputs changing during a blit have no effect.

Test Plan:
1. Params IMG_W=4, IMG_H=2, ROM model = index k, dst=(0,0), key_en=0, start at E0 -> plots at E0+2..E0+9 with (x,y) = (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1) and colour = k mod 8; done at E0+10; busy high 10 cycles.
2. Same params, dst=(158,119) with default SCR 160x120 -> only pixels (0,0),(1,0) plot at screen (158,119),(159,119); the other 6 suppressed; done still pulses.
3. key_en=1, ROM returns 0 for even k -> vga_plot only on odd k; key_en=0 repeat -> all 8 plot.
4. Assert rst during RUN at pixel 3 -> all outputs 0 in the same cycle, no done; next start runs a full clean blit.
5. start held high continuously and pulsed mid-blit -> exactly one blit per IDLE entry; the second blit starts 1 cycle after done.
6. Default params, dst=(0,0) -> 19200 plots, last at (159,119), done at E0+19202.
